// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - score-ROM driven note sequencer for one synthesizer voice
// Steps through {gate, div, dur} events at a tempo tick; drives div_num/gate to the voice.
module score_sequencer #(
    parameter int unsigned      TICK_DIV    = 1399999,
    parameter int unsigned      DIV_W       = 11,
    parameter int unsigned      DUR_W       = 8,
    parameter int unsigned      ADDR_W      = 5,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 11'd238
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    output logic [ADDR_W-1:0]      ev_addr,
    input  logic [DIV_W+DUR_W:0]   ev_data,
    output logic [DIV_W-1:0]       div_num,
    output logic                   gate,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned       TICK_W    = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ev_addr_q, ev_addr_d;
    logic [DIV_W-1:0]    div_num_q, div_num_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;

    logic                ev_gate;
    logic [DIV_W-1:0]    ev_div;
    logic [DUR_W-1:0]    ev_dur;
    logic                tick;
    logic                note_end;
    logic                end_hit;
    logic                restart;
    logic                finish;

    assign ev_gate = ev_data[DIV_W+DUR_W];
    assign ev_div  = ev_data[DUR_W +: DIV_W];
    assign ev_dur  = ev_data[DUR_W-1:0];

    assign tick     = (state_q == S_PLAY) && (tick_cnt_q == TICK_W'(TICK_DIV));
    assign note_end = tick && (dur_cnt_q == DUR_W'(1));

    // Expiry of the last address behaves exactly like reading an end marker.
    assign end_hit = ((state_q == S_LOAD) && (ev_dur == '0))
                   || (note_end && (ev_addr_q == LAST_ADDR));
    // An end marker at address 0 never loops, so an empty score always terminates.
    assign restart = end_hit && loop_en && (ev_addr_q != '0);
    assign finish  = end_hit && !restart;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            ev_addr_q  <= '0;
            div_num_q  <= DEFAULT_DIV;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dur_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ev_addr_q  <= ev_addr_d;
            div_num_q  <= div_num_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dur_cnt_q  <= dur_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = S_FETCH;
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    if (finish)       state_d = S_IDLE;
                    else if (restart) state_d = S_FETCH;
                    else              state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (note_end) state_d = finish ? S_IDLE : S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_addr_d  = ev_addr_q;
        div_num_d  = div_num_q;
        gate_d     = gate_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dur_cnt_d  = dur_cnt_q;
        tick_cnt_d = '0;

        if (stop) begin
            ev_addr_d = '0;
            gate_d    = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ev_addr_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                S_FETCH: ;
                S_LOAD: begin
                    if (finish) begin
                        gate_d = 1'b0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else if (restart) begin
                        ev_addr_d = '0;
                    end else begin
                        div_num_d = ev_div;
                        gate_d    = ev_gate;
                        dur_cnt_d = ev_dur;
                    end
                end
                S_PLAY: begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
                    if (tick) dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (note_end) begin
                        if (finish) begin
                            gate_d = 1'b0;
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end else if (restart) begin
                            ev_addr_d = '0;
                        end else begin
                            ev_addr_d = ev_addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ev_addr = ev_addr_q;
    assign div_num = div_num_q;
    assign gate    = gate_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - self-checking bench for score_sequencer
// Reference model schedules loads and note ends as absolute edge numbers.
module tb_score_sequencer;

    localparam int TD     = 3;
    localparam int ADDR_W = 2;
    localparam int NEV    = 4;

    logic        clk = 1'b0;
    logic        nRST = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [1:0]  ev_addr;
    logic [19:0] ev_data = '0;
    logic [10:0] div_num;
    logic        gate;
    logic        busy;
    logic        done;

    score_sequencer #(
        .TICK_DIV   (TD),
        .DIV_W      (11),
        .DUR_W      (8),
        .ADDR_W     (ADDR_W),
        .DEFAULT_DIV(11'd238)
    ) dut (
        .clk    (clk),
        .nRST   (nRST),
        .start  (start),
        .stop   (stop),
        .loop_en(loop_en),
        .ev_addr(ev_addr),
        .ev_data(ev_data),
        .div_num(div_num),
        .gate   (gate),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    logic [19:0] rom [NEV];
    always @(posedge clk) ev_data <= rom[ev_addr];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [19:0] mk(input logic g, input int dv, input int dr);
        logic [10:0] d11;
        logic [7:0]  d8;
        d11 = 11'(dv);
        d8  = 8'(dr);
        return {g, d11, d8};
    endfunction

    // Reference model: expected outputs for the cycle following each edge.
    longint now = 0;
    longint load_edge = -1;
    longint play_end = -1;
    int     m_addr = 0;
    int     m_div = 238;
    bit     m_gate = 0;
    bit     m_busy = 0;
    bit     m_done = 0;

    task automatic model_reset();
        m_addr = 0; m_div = 238; m_gate = 0; m_busy = 0; m_done = 0;
        load_edge = -1; play_end = -1;
    endtask

    task automatic end_rule();
        if (loop_en && m_addr != 0) begin
            m_addr    = 0;
            load_edge = now + 2;
        end else begin
            m_gate = 0;
            m_done = 1;
            m_busy = 0;
        end
    endtask

    task automatic model_step();
        logic [19:0] w;
        now++;
        m_done = 0;
        if (!nRST) begin
            model_reset();
        end else if (stop) begin
            m_busy = 0; m_gate = 0; m_addr = 0;
            load_edge = -1; play_end = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy    = 1;
                m_addr    = 0;
                load_edge = now + 2;
            end
        end else if (now == load_edge) begin
            load_edge = -1;
            w = rom[m_addr];
            if (w[7:0] == 0) begin
                end_rule();
            end else begin
                m_div    = int'(w[18:8]);
                m_gate   = w[19];
                play_end = now + longint'(w[7:0]) * (TD + 1);
            end
        end else if (now == play_end) begin
            play_end = -1;
            if (m_addr == NEV - 1) end_rule();
            else begin
                m_addr++;
                load_edge = now + 2;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (nRST) begin
            check("model_ev_addr", 32'(ev_addr), 32'(m_addr));
            check("model_div_num", 32'(div_num), 32'(m_div));
            check("model_gate",    32'(gate),    32'(m_gate));
            check("model_busy",    32'(busy),    32'(m_busy));
            check("model_done",    32'(done),    32'(m_done));
        end
    end

    task automatic settle();
        @(negedge clk);
        start = 0; stop = 1;
        repeat (2) @(negedge clk);
        stop = 0;
        @(negedge clk);
    endtask

    task automatic load_basic();
        rom[0] = mk(1, 189, 2);
        rom[1] = mk(0, 189, 1);
        rom[2] = mk(1, 238, 3);
        rom[3] = mk(0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NEV; i++) rom[i] = '0;

        #1 nRST = 0;
        #1;
        check("rst_ev_addr", 32'(ev_addr), 0);
        check("rst_div_num", 32'(div_num), 238);
        check("rst_gate",    32'(gate),    0);
        check("rst_busy",    32'(busy),    0);
        check("rst_done",    32'(done),    0);
        repeat (3) @(negedge clk);
        #2 nRST = 1;
        @(negedge clk);

        // Basic score
        load_basic();
        loop_en = 0;
        start = 1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 1)  check("basic_busy_t1", 32'(busy), 1);
            if (k == 3)  begin check("basic_div_t3", 32'(div_num), 189); check("basic_gate_t3", 32'(gate), 1); end
            if (k == 13) begin check("basic_rest_gate", 32'(gate), 0); check("basic_rest_div", 32'(div_num), 189); end
            if (k == 19) begin check("basic_div_t19", 32'(div_num), 238); check("basic_gate_t19", 32'(gate), 1); end
            if (k == 32) check("basic_busy_t32", 32'(busy), 1);
            if (k == 33) begin
                check("basic_done_t33", 32'(done), 1);
                check("basic_gate_t33", 32'(gate), 0);
                check("basic_busy_t33", 32'(busy), 0);
            end
            if (k == 34) check("basic_done_t34", 32'(done), 0);
        end

        // Loop then stop
        settle();
        load_basic();
        loop_en = 1;
        start = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 33) begin check("loop_addr0", 32'(ev_addr), 0); check("loop_busy", 32'(busy), 1); check("loop_nodone", 32'(done), 0); end
            if (k == 34) check("loop_div_hold", 32'(div_num), 238);
            if (k == 35) begin check("loop_div_again", 32'(div_num), 189); check("loop_gate_again", 32'(gate), 1); end
            if (k == 37) stop = 1;
            if (k == 38) begin
                stop = 0;
                check("stop_gate", 32'(gate), 0);
                check("stop_busy", 32'(busy), 0);
                check("stop_done", 32'(done), 0);
                check("stop_addr", 32'(ev_addr), 0);
            end
        end

        // Empty score with loop enabled
        settle();
        rom[0] = mk(1, 77, 0);
        loop_en = 1;
        start = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 2) check("empty_busy_t2", 32'(busy), 1);
            if (k == 3) begin check("empty_done_t3", 32'(done), 1); check("empty_busy_t3", 32'(busy), 0); end
            if (k == 4) begin check("empty_done_t4", 32'(done), 0); check("empty_addr_t4", 32'(ev_addr), 0); end
        end

        // Full-length score, with a start pulse ignored during PLAY
        settle();
        rom[0] = mk(1, 100, 1);
        rom[1] = mk(1, 120, 1);
        rom[2] = mk(0, 140, 1);
        rom[3] = mk(1, 160, 1);
        loop_en = 0;
        start = 1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 3)  check("full_div0", 32'(div_num), 100);
            if (k == 9)  check("full_div1", 32'(div_num), 120);
            if (k == 15) begin check("full_div2", 32'(div_num), 140); check("full_rest", 32'(gate), 0); end
            if (k == 21) begin check("full_div3", 32'(div_num), 160); check("full_addr3", 32'(ev_addr), 3); end
            if (k == 24) check("full_busy_t24", 32'(busy), 1);
            if (k == 25) begin check("full_done", 32'(done), 1); check("full_gate_off", 32'(gate), 0); end
        end

        // start and stop together
        settle();
        start = 1; stop = 1;
        @(negedge clk);
        start = 0; stop = 0;
        check("ss_busy", 32'(busy), 0);
        @(negedge clk);
        check("ss_busy_after", 32'(busy), 0);
        check("ss_addr", 32'(ev_addr), 0);

        // Asynchronous reset mid-PLAY
        settle();
        rom[0] = mk(1, 178, 5);
        rom[1] = mk(1, 200, 1);
        loop_en = 0;
        start = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 3) check("pre_rst_div", 32'(div_num), 178);
        end
        #2 nRST = 0;
        #1;
        check("mid_rst_gate", 32'(gate), 0);
        check("mid_rst_div",  32'(div_num), 238);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(ev_addr), 0);
        @(negedge clk);
        #2 nRST = 1;
        @(negedge clk);
        start = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 0;
            if (k == 3) begin check("replay_div", 32'(div_num), 178); check("replay_gate", 32'(gate), 1); end
        end

        // Randomized scores and control traffic
        for (int blk = 0; blk < 8; blk++) begin
            settle();
            for (int i = 0; i < NEV; i++)
                rom[i] = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                start   = ($urandom_range(0, 5) == 0);
                stop    = ($urandom_range(0, 59) == 0);
                loop_en = ($urandom_range(0, 2) != 0);
            end
            start = 0; stop = 0;
        end

        settle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
